// File: rtl/mmio_bus_pkg.sv
// Shared defaults and decode-target type for the OTTER IOBUS peripheral controller.
package mmio_bus_pkg;

    localparam logic [31:0] DEF_OUT_BASE = 32'h1108_0000;
    localparam logic [31:0] DEF_IN_BASE  = 32'h1100_0000;
    localparam logic [31:0] DEF_STRIDE   = 32'h0004_0000;
    localparam logic [31:0] DEF_MASK_AD  = 32'h11F8_0000;
    localparam logic [31:0] DEF_STAT_AD  = 32'h11FC_0000;
    localparam logic [31:0] DEF_WIN_BASE = 32'h2000_0000;
    localparam int          DEF_WIN_BITS = 13;

    typedef enum logic [2:0] {
        TGT_WIN,
        TGT_OUT,
        TGT_IN,
        TGT_MASK,
        TGT_STAT,
        TGT_NONE
    } tgt_e;

endpackage

// File: rtl/mmio_bus_ctrl_in_sync_detect.sv
// Two-flop synchroniser for one input port, with a previous-value flop
// whose mismatch against the synced value flags a change.
module in_sync_detect #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] async_in,
    output logic [W-1:0] synced,
    output logic         change
);

    logic [W-1:0] meta;
    logic [W-1:0] stable;
    logic [W-1:0] prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= '0;
            stable <= '0;
            prev   <= '0;
        end else begin
            meta   <= async_in;
            stable <= meta;
            prev   <= stable;
        end
    end

    assign synced = stable;
    assign change = |(stable ^ prev);

endmodule

// File: rtl/mmio_bus_ctrl.sv
// IOBUS decode for output registers, synchronised input ports, a registered
// byte window and change-detect status with a maskable level interrupt.
module mmio_bus_ctrl
    import mmio_bus_pkg::*;
#(
    parameter int          NUM_OUT  = 2,
    parameter int          NUM_IN   = 2,
    parameter int          OUT_W    = 16,
    parameter int          IN_W     = 16,
    parameter logic [31:0] OUT_BASE = DEF_OUT_BASE,
    parameter logic [31:0] IN_BASE  = DEF_IN_BASE,
    parameter logic [31:0] STRIDE   = DEF_STRIDE,
    parameter logic [31:0] MASK_AD  = DEF_MASK_AD,
    parameter logic [31:0] STAT_AD  = DEF_STAT_AD,
    parameter logic [31:0] WIN_BASE = DEF_WIN_BASE,
    parameter int          WIN_BITS = DEF_WIN_BITS
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic [31:0]              IOBUS_ADDR,
    input  logic [31:0]              IOBUS_OUT,
    input  logic                     IOBUS_WR,
    output logic [31:0]              IOBUS_IN,
    input  logic [NUM_IN*IN_W-1:0]   IN_PORTS,
    output logic [NUM_OUT*OUT_W-1:0] OUT_PORTS,
    output logic                     WIN_WE,
    output logic [WIN_BITS-1:0]      WIN_WA,
    output logic [7:0]               WIN_WD,
    input  logic [7:0]               WIN_RD,
    output logic                     IRQ
);

    tgt_e                tgt;
    logic [NUM_OUT-1:0]  out_sel;
    logic [NUM_IN-1:0]   in_sel;
    logic [OUT_W-1:0]    out_reg [NUM_OUT];
    logic [IN_W-1:0]     in_val  [NUM_IN];
    logic [NUM_IN-1:0]   chg;
    logic [NUM_IN-1:0]   mask;
    logic [NUM_IN-1:0]   stat;
    logic [NUM_IN-1:0]   stat_clr;
    logic [1:0]          prime_cnt;
    logic                primed;
    logic                unused_wdata;

    assign unused_wdata = ^IOBUS_OUT;

    // Window match outranks every exact-address target.
    always_comb begin
        for (int k = 0; k < NUM_OUT; k++)
            out_sel[k] = (IOBUS_ADDR == OUT_BASE + STRIDE * 32'(k));
        for (int k = 0; k < NUM_IN; k++)
            in_sel[k] = (IOBUS_ADDR == IN_BASE + STRIDE * 32'(k));
        if (IOBUS_ADDR[31:WIN_BITS] == WIN_BASE[31:WIN_BITS])
            tgt = TGT_WIN;
        else if (|out_sel)
            tgt = TGT_OUT;
        else if (|in_sel)
            tgt = TGT_IN;
        else if (IOBUS_ADDR == MASK_AD)
            tgt = TGT_MASK;
        else if (IOBUS_ADDR == STAT_AD)
            tgt = TGT_STAT;
        else
            tgt = TGT_NONE;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int k = 0; k < NUM_OUT; k++)
                out_reg[k] <= '0;
        end else if (IOBUS_WR && tgt == TGT_OUT) begin
            for (int k = 0; k < NUM_OUT; k++)
                if (out_sel[k])
                    out_reg[k] <= IOBUS_OUT[OUT_W-1:0];
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign OUT_PORTS[g*OUT_W +: OUT_W] = out_reg[g];
    end

    for (genvar g = 0; g < NUM_IN; g++) begin : g_in
        in_sync_detect #(
            .W(IN_W)
        ) u_sync (
            .clk     (CLK),
            .rst_n   (RESET_N),
            .async_in(IN_PORTS[g*IN_W +: IN_W]),
            .synced  (in_val[g]),
            .change  (chg[g])
        );
    end

    // Hold off change detection until the synchronisers have flushed reset-time levels.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            prime_cnt <= 2'd0;
        else if (prime_cnt != 2'd3)
            prime_cnt <= prime_cnt + 2'd1;
    end

    assign primed   = (prime_cnt == 2'd3);
    assign stat_clr = (IOBUS_WR && tgt == TGT_STAT) ? IOBUS_OUT[NUM_IN-1:0] : '0;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mask <= '0;
            stat <= '0;
        end else begin
            if (IOBUS_WR && tgt == TGT_MASK)
                mask <= IOBUS_OUT[NUM_IN-1:0];
            stat <= (stat & ~stat_clr) | (primed ? chg : '0);
        end
    end

    assign IRQ = |(stat & mask);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            WIN_WE <= 1'b0;
            WIN_WA <= '0;
            WIN_WD <= '0;
        end else begin
            WIN_WE <= IOBUS_WR && (tgt == TGT_WIN);
            WIN_WA <= IOBUS_ADDR[WIN_BITS-1:0];
            WIN_WD <= IOBUS_OUT[7:0];
        end
    end

    always_comb begin
        IOBUS_IN = '0;
        case (tgt)
            TGT_WIN:  IOBUS_IN = {24'b0, WIN_RD};
            TGT_IN: begin
                for (int k = 0; k < NUM_IN; k++)
                    if (in_sel[k])
                        IOBUS_IN = 32'(in_val[k]);
            end
            TGT_OUT: begin
                for (int k = 0; k < NUM_OUT; k++)
                    if (out_sel[k])
                        IOBUS_IN = 32'(out_reg[k]);
            end
            TGT_MASK: IOBUS_IN = 32'(mask);
            TGT_STAT: IOBUS_IN = 32'(stat);
            default:  IOBUS_IN = '0;
        endcase
    end

endmodule
